// File: rtl/banked_mem_emulator_if.sv
// ---------------------------------------------------------------------------
// banked_mem_emulator_if
// One requester port of the banked memory emulator.
//   Requester -> memory : cenb_i (active-low enable), wenb_i (0 write, 1 read),
//                         addr_i (MSB allows out-of-range), d_i, wmask_i
//   Memory -> requester : stall_o (combinational), q_o, rvalid_o, err_o,
//                         stall_cnt_o (saturating)
// The master modport is the requester side, the slave modport the memory.
// ---------------------------------------------------------------------------
interface banked_mem_emulator_if #(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8,
    parameter int SIZE   = 256,
    parameter int CNT_W  = 16
);
    localparam int LANES = WIDTH / LANE_W;
    localparam int AW    = $clog2(SIZE) + 1;

    logic              cenb_i;
    logic              wenb_i;
    logic [AW-1:0]     addr_i;
    logic [WIDTH-1:0]  d_i;
    logic [LANES-1:0]  wmask_i;
    logic              stall_o;
    logic [WIDTH-1:0]  q_o;
    logic              rvalid_o;
    logic              err_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output cenb_i, wenb_i, addr_i, d_i, wmask_i,
        input  stall_o, q_o, rvalid_o, err_o, stall_cnt_o
    );

    modport slave (
        input  cenb_i, wenb_i, addr_i, d_i, wmask_i,
        output stall_o, q_o, rvalid_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/banked_mem_emulator.sv
// ---------------------------------------------------------------------------
// banked_mem_emulator
// Dual-port, low-order-interleaved multi-bank behavioural SRAM.
//   clk_i        : single clock, rising edge
//   rstn_async_i : asynchronous active-low reset (memory contents retained)
//   prio_b_i     : 1 -> port B wins bank conflicts, 0 -> port A wins
//   port_a/b     : requester ports (see banked_mem_emulator_if)
// Because banks are interleaved on the low address bits, the physical word
// index equals the address itself; banks only matter for conflict detection.
// ---------------------------------------------------------------------------
module banked_mem_emulator #(
    parameter int WIDTH      = 32,
    parameter int LANE_W     = 8,
    parameter int SIZE       = 256,
    parameter int BANKS      = 2,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_async_i,
    input  logic                  prio_b_i,
    banked_mem_emulator_if.slave  port_a,
    banked_mem_emulator_if.slave  port_b
);
    localparam int LANES = WIDTH / LANE_W;
    localparam int AW    = $clog2(SIZE) + 1;
    localparam int IW    = AW - 1;
    localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;

    // Merge new data into an old word, lane by lane, under the write mask.
    function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_w,
                                                 input logic [WIDTH-1:0] new_w,
                                                 input logic [LANES-1:0] mask);
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) begin
                res[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] r_mem [SIZE];

    // Index 0 = port A, index 1 = port B.
    logic [1:0]        w_cenb, w_wenb, w_req, w_inr, w_stall, w_acc, w_nv, w_ne;
    logic [AW-1:0]     w_addr  [2];
    logic [WIDTH-1:0]  w_d     [2];
    logic [WIDTH-1:0]  w_rdata [2];
    logic [LANES-1:0]  w_wmask [2];
    logic              w_conflict;
    logic              w_same_bank;

    logic [RD_LATENCY-1:0] r_pv  [2];
    logic [RD_LATENCY-1:0] r_pe  [2];
    logic [WIDTH-1:0]      r_pd  [2][RD_LATENCY];
    logic [CNT_W-1:0]      r_cnt [2];

    assign w_cenb     = {port_b.cenb_i, port_a.cenb_i};
    assign w_wenb     = {port_b.wenb_i, port_a.wenb_i};
    assign w_addr[0]  = port_a.addr_i;
    assign w_addr[1]  = port_b.addr_i;
    assign w_d[0]     = port_a.d_i;
    assign w_d[1]     = port_b.d_i;
    assign w_wmask[0] = port_a.wmask_i;
    assign w_wmask[1] = port_b.wmask_i;

    // Request decode, bank conflict arbitration and combinational read fetch.
    always_comb begin
        w_req       = 2'b00;
        w_inr       = 2'b00;
        w_stall     = 2'b00;
        w_acc       = 2'b00;
        w_nv        = 2'b00;
        w_ne        = 2'b00;
        w_rdata[0]  = '0;
        w_rdata[1]  = '0;
        for (int p = 0; p < 2; p++) begin
            w_req[p] = ~w_cenb[p];
            w_inr[p] = (w_addr[p] < AW'(SIZE));
        end
        if (BANKS == 1) begin
            w_same_bank = 1'b1;
        end else begin
            w_same_bank = (w_addr[0][BW-1:0] == w_addr[1][BW-1:0]);
        end
        // Out-of-range requests occupy no bank, so they never conflict.
        w_conflict = w_req[0] & w_req[1] & w_inr[0] & w_inr[1] & w_same_bank;
        w_stall[0] = w_conflict & prio_b_i;
        w_stall[1] = w_conflict & ~prio_b_i;
        for (int p = 0; p < 2; p++) begin
            w_acc[p] = w_req[p] & ~w_stall[p];
            w_nv[p]  = w_acc[p] & w_wenb[p];
            w_ne[p]  = w_acc[p] & ~w_inr[p];
            if (w_inr[p]) begin
                w_rdata[p] = r_mem[w_addr[p][IW-1:0]];
            end else begin
                w_rdata[p] = '0;
            end
        end
    end

    // Memory array: accepted in-range writes, never reset.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < 2; p++) begin
            if (w_acc[p] && !w_wenb[p] && w_inr[p]) begin
                r_mem[w_addr[p][IW-1:0]] <= f_merge(r_mem[w_addr[p][IW-1:0]], w_d[p], w_wmask[p]);
            end
        end
    end

    // Per-port read pipelines; the last data stage is q and only loads on valid.
    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            for (int p = 0; p < 2; p++) begin
                r_pv[p] <= '0;
                r_pe[p] <= '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    r_pd[p][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_pv[p][0] <= w_nv[p];
                r_pe[p][0] <= w_ne[p];
                if ((RD_LATENCY > 1) || w_nv[p]) begin
                    r_pd[p][0] <= w_rdata[p];
                end
                for (int i = 1; i < RD_LATENCY; i++) begin
                    r_pv[p][i] <= r_pv[p][i-1];
                    r_pe[p][i] <= r_pe[p][i-1];
                    if ((i < RD_LATENCY - 1) || r_pv[p][i-1]) begin
                        r_pd[p][i] <= r_pd[p][i-1];
                    end
                end
            end
        end
    end

    // Saturating stall counters.
    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_stall[p] && (r_cnt[p] != {CNT_W{1'b1}})) begin
                    r_cnt[p] <= r_cnt[p] + CNT_W'(1);
                end
            end
        end
    end

    assign port_a.stall_o     = w_stall[0];
    assign port_b.stall_o     = w_stall[1];
    assign port_a.q_o         = r_pd[0][RD_LATENCY-1];
    assign port_b.q_o         = r_pd[1][RD_LATENCY-1];
    assign port_a.rvalid_o    = r_pv[0][RD_LATENCY-1];
    assign port_b.rvalid_o    = r_pv[1][RD_LATENCY-1];
    assign port_a.err_o       = r_pe[0][RD_LATENCY-1];
    assign port_b.err_o       = r_pe[1][RD_LATENCY-1];
    assign port_a.stall_cnt_o = r_cnt[0];
    assign port_b.stall_cnt_o = r_cnt[1];
endmodule
